crossing_cmd_scheduler: RTL

- Sits between the debounced BTN7..BTN4 pulses and the game core.
- Edge-detects the four move buttons and arbitrates simultaneous presses by fixed priority.
- Buffers moves in a small FIFO and issues them one at a time to the core over a valid/ack handshake, enforcing a settle gap after each crossing finishes.
- The core stays the sole owner of legality checks; this block only sequences requests.

---
 rtl/crossing_cmd_if.sv | 21 ++
 rtl/crossing_cmd_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crossing_cmd_if.sv
// Command handshake between the move scheduler (master) and the game core (slave).
interface crossing_cmd_if;
    logic       cmd_valid;
    logic [1:0] cmd_sel;
    logic       cmd_ack;
    logic       core_busy;

    modport master (
        output cmd_valid,
        output cmd_sel,
        input  cmd_ack,
        input  core_busy
    );

    modport slave (
        input  cmd_valid,
        input  cmd_sel,
        output cmd_ack,
        output core_busy
    );
endinterface

// File: rtl/crossing_cmd_scheduler.sv
// Edge-detects the four move buttons, arbitrates by fixed priority, queues moves and
// hands them to the game core one at a time with an ack timeout and a post-crossing gap.
//
// state         | meaning
// ST_IDLE       | nothing outstanding; issue the head when enabled and the queue is not empty
// ST_ISSUE      | cmd_valid high, waiting for cmd_ack or the ack timeout
// ST_WAIT_BUSY  | command accepted, waiting for the core to finish the crossing
// ST_GAP        | settle gap after the crossing before the next issue
module crossing_cmd_scheduler #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                   clk_4Hz,
    input  logic                   rst,
    input  logic                   sw6,
    input  logic                   sw5,
    input  logic                   game_active,
    input  logic                   btn_7_out,
    input  logic                   btn_6_out,
    input  logic                   btn_5_out,
    input  logic                   btn_4_out,
    input  logic                   btn_0_out,
    crossing_cmd_if.master         cmd_bus,
    output logic [$clog2(DEPTH):0] queue_level,
    output logic                   queue_full,
    output logic [3:0]             drop_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam bit GAP_EN = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               no_gap_q, no_gap_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [1:0]         cmd_sel_q, cmd_sel_d;
    logic [3:0]         prev_btn_q, prev_btn_d;
    logic               prev_btn0_q, prev_btn0_d;
    logic [1:0]         mem_q [DEPTH];
    logic [1:0]         mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               full_q, full_d;
    logic [3:0]         drop_cnt_q, drop_cnt_d;

    logic               enable;
    logic               flush_btn;
    logic               flush;
    logic [3:0]         btn_now;
    logic [3:0]         rise;
    logic               any_rise;
    logic [2:0]         rise_cnt;
    logic [2:0]         loser_cnt;
    logic [1:0]         cand_sel;
    logic               pop;
    logic               tmo_drop;
    logic               push_req;
    logic               push;
    logic               full_drop;
    logic [4:0]         drop_sum;

    always_comb begin
        enable      = sw6 & ~sw5 & game_active;
        btn_now     = {btn_7_out, btn_6_out, btn_5_out, btn_4_out};
        rise        = btn_now & ~prev_btn_q;
        any_rise    = |rise;
        flush_btn   = btn_0_out & ~prev_btn0_q;
        flush       = flush_btn | ~sw6;
        prev_btn_d  = btn_now;
        prev_btn0_d = btn_0_out;
        rise_cnt    = 3'(rise[3]) + 3'(rise[2]) + 3'(rise[1]) + 3'(rise[0]);
        loser_cnt   = (any_rise && enable && !flush) ? (rise_cnt - 3'd1) : 3'd0;
        // cat (btn7) wins over dog, mouse and canoe in that order
        if (rise[3]) begin
            cand_sel = 2'd0;
        end else if (rise[2]) begin
            cand_sel = 2'd1;
        end else if (rise[1]) begin
            cand_sel = 2'd2;
        end else begin
            cand_sel = 2'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        no_gap_d    = no_gap_q;
        cmd_valid_d = cmd_valid_q;
        cmd_sel_d   = cmd_sel_q;
        pop         = 1'b0;
        tmo_drop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_valid_d = 1'b0;
                if (enable && !flush && (level_q != '0)) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_sel_d   = mem_q[rd_ptr_q];
                    cnt_d       = 4'(ACK_TIMEOUT - 1);
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (cmd_bus.cmd_ack) begin
                    pop         = 1'b1;
                    cmd_valid_d = 1'b0;
                    state_d     = ST_WAIT_BUSY;
                    first_d     = 1'b1;
                    no_gap_d    = 1'b0;
                end else if (!enable) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    pop         = 1'b1;
                    tmo_drop    = 1'b1;
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WAIT_BUSY: begin
                // a flush here only cancels the settle gap; the crossing itself must finish
                if (flush) begin
                    no_gap_d = 1'b1;
                end
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!cmd_bus.core_busy) begin
                    if (no_gap_q || flush || !GAP_EN) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = 4'(GAP_CYCLES);
                    end
                end
            end
            ST_GAP: begin
                if (flush || (cnt_q <= 4'd1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        push_req  = enable & ~flush & any_rise;
        push      = push_req & (~full_q | pop);
        full_drop = push_req & full_q & ~pop;
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = cand_sel;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end
        full_d   = (level_d == LVL_W'(DEPTH));
        drop_sum = 5'(drop_cnt_q) + 5'(loser_cnt) + 5'(full_drop) + 5'(tmo_drop);
        if (flush_btn) begin
            drop_cnt_d = 4'd0;
        end else if (flush) begin
            drop_cnt_d = drop_cnt_q;
        end else if (drop_sum > 5'd15) begin
            drop_cnt_d = 4'd15;
        end else begin
            drop_cnt_d = drop_sum[3:0];
        end
    end

    always_ff @(posedge clk_4Hz or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            first_q     <= 1'b0;
            no_gap_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_sel_q   <= 2'd0;
            prev_btn_q  <= 4'd0;
            prev_btn0_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            drop_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            no_gap_q    <= no_gap_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_sel_q   <= cmd_sel_d;
            prev_btn_q  <= prev_btn_d;
            prev_btn0_q <= prev_btn0_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign cmd_bus.cmd_valid = cmd_valid_q;
    assign cmd_bus.cmd_sel   = cmd_sel_q;
    assign queue_level       = level_q;
    assign queue_full        = full_q;
    assign drop_cnt          = drop_cnt_q;

endmodule
